data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the load/store control outputs (MemRead, MemWrite, opcode) produced by the instruction decoder.
- Accepts one access per request. Holds the core with stall while the access is in progress, then completes it after a fixed latency.
- Supports byte, half-word and word accesses with sign/zero extension and alignment checking.
- Sits between the datapath (ALU result as address, rt as store data) and a word-organised on-chip RAM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM. Must be a power of 2.
- LATENCY, 2, cycles spent in BUSY before completion. Minimum 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  load request from the control unit.
- mem_write  input  1  store request from the control unit.
- opcode  input  6  instruction opcode; selects access size and extension.
- addr  input  32  byte address.
- wdata  input  32  store data.
- rdata  output  32  load result, already extended.
- ready  output  1  one-cycle completion pulse.
- stall  output  1  hold request to the core.
- addr_err  output  1  one-cycle error pulse, coincident with ready.

Behaviour:
- Opcode map (little-endian, byte 0 = bits 7:0):
  - 32 lb: sign-extended byte.
  - 33 lh: sign-extended half.
  - 35 lw: word.
  - 36 lbu: zero-extended byte.
  - 37 lhu: zero-extended half.
  - 40 sb, 41 sh, 43 sw: store byte, half, word.
- Word index = addr[log2(DEPTH_WORDS)+1 : 2]. Higher address bits are ignored, so accesses wrap modulo the RAM size.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if mem_read or mem_write is 1, latch opcode, addr, wdata and the request type; load counter with LATENCY-1; go to BUSY. Otherwise stay in IDLE.
  - BUSY: decrement the counter each cycle. When the counter is 0, go to DONE. Store data is written to RAM on this transition edge (byte enables per size and addr[1:0]).
  - DONE: ready=1 for exactly one cycle, then go to IDLE. A request present in the following IDLE cycle is treated as a new access.
- stall = (mem_read or mem_write) and state != DONE. It is combinational from the inputs and the state.
- Request inputs are sampled only in IDLE. Changes during BUSY are ignored.
- Error conditions. Any of these raises addr_err in the DONE cycle, suppresses the RAM write and forces rdata to 0:
  - lw/sw with addr[1:0] != 0.
  - lh/lhu/sh with addr[0] != 0.
  - Opcode not in the map.
  - mem_read and mem_write both 1.
- rdata: valid only in the DONE cycle of a successful load. Held at 0 in every other cycle, including store completions.
- Latency: request seen in IDLE at edge N; ready high in cycle N+LATENCY+1.
- Reset (any time, including BUSY): state goes to IDLE, the counter clears, and ready, addr_err and rdata go to 0. A pending store is discarded because the write has not yet occurred. RAM contents are not affected by reset.
- Reset values: rdata=0, ready=0, addr_err=0. stall follows its equation with state=IDLE.
- Store byte lanes:
  - sb writes wdata[7:0] into lane addr[1:0].
  - sh writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 (LATENCY=2) -> stall high 3 cycles per access; ready at request+3; rdata=0xDEADBEEF; addr_err=0.
- sb 0x80 @0x21, then lb @0x21 and lbu @0x21 -> rdata 0xFFFFFF80 and 0x00000080. lw @0x20 shows byte 1 = 0x80 and other bytes unchanged.
- sh 0x8001 @0x32, then lh and lhu @0x32 -> rdata 0xFFFF8001 and 0x00008001.
- Misaligned/illegal access:
  - lw @0x13 -> ready and addr_err pulse together, rdata=0.
  - sw @0x12 -> ready and addr_err pulse together, rdata=0; a later lw @0x10 returns the old value.
  - mem_read and mem_write both 1 -> ready and addr_err pulse together, rdata=0.
- Wrap-around: sw 0x12345678 @(DEPTH_WORDS*4+0x4), then lw @0x4 -> 0x12345678.
- Reset asserted while BUSY during sw 0xAAAAAAAA @0x8 -> outputs clear immediately (ready=0, addr_err=0, rdata=0) and state returns to IDLE. After release, lw @0x8 returns the prior contents, so the store was not committed.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: takes one load/store per request, stalls the core for
// a fixed latency, then completes with size/extension handling and error checks.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // size: 0 byte, 1 half, 2 word
    typedef struct packed {
        logic       valid;
        logic       load;
        logic       store;
        logic [1:0] size;
        logic       sext;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = 6'd0;
        case (op)
            6'd32:   d = {1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
            6'd33:   d = {1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
            6'd35:   d = {1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
            6'd36:   d = {1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
            6'd37:   d = {1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
            6'd40:   d = {1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
            6'd41:   d = {1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
            6'd43:   d = {1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
            default: d = 6'd0;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = lo[0];
            default: m = (lo != 2'd0);
        endcase
        return m;
    endfunction

    state_t          state_r, state_n;
    logic [CW-1:0]   cnt_r;
    logic [5:0]      op_r;
    logic [AW+1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic            rd_r, wr_r;
    logic [31:0]     rdata_r;
    logic            ready_r, addr_err_r;
    logic [31:0]     mem_r [DEPTH_WORDS];

    logic            req_s, finish_s, err_s, we_s;
    dec_t            dec_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     word_s, load_val_s, wd_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;
    logic [3:0]      be_s;
    logic            unused_addr_s;

    assign unused_addr_s = ^addr[31:AW+2];

    assign req_s    = mem_read | mem_write;
    assign stall    = req_s & (state_r != DONE);
    assign rdata    = rdata_r;
    assign ready    = ready_r;
    assign addr_err = addr_err_r;

    assign dec_s    = decode(op_r);
    assign idx_s    = addr_r[AW+1:2];
    assign word_s   = mem_r[idx_s];
    assign finish_s = (state_r == BUSY) && (cnt_r == {CW{1'b0}});
    // A request type that disagrees with the opcode is treated like an unmapped opcode.
    assign err_s    = !dec_s.valid || (rd_r && wr_r) || misaligned(dec_s.size, addr_r[1:0])
                      || (rd_r && !dec_s.load) || (wr_r && !dec_s.store);
    assign we_s     = finish_s && wr_r && !err_s;

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) state_n = BUSY;
                else       state_n = IDLE;
            end
            BUSY: begin
                if (cnt_r == {CW{1'b0}}) state_n = DONE;
                else                     state_n = BUSY;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Load data extraction and extension
    always_comb begin
        byte_s     = 8'd0;
        load_val_s = 32'd0;
        case (addr_r[1:0])
            2'd0:    byte_s = word_s[7:0];
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            default: byte_s = word_s[31:24];
        endcase
        half_s = addr_r[1] ? word_s[31:16] : word_s[15:0];
        case (dec_s.size)
            2'd0:    load_val_s = dec_s.sext ? {{24{byte_s[7]}}, byte_s} : {24'd0, byte_s};
            2'd1:    load_val_s = dec_s.sext ? {{16{half_s[15]}}, half_s} : {16'd0, half_s};
            default: load_val_s = word_s;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        be_s = 4'b0000;
        wd_s = 32'd0;
        case (dec_s.size)
            2'd0: begin
                be_s = 4'b0001 << addr_r[1:0];
                wd_s = {4{wdata_r[7:0]}};
            end
            2'd1: begin
                be_s = addr_r[1] ? 4'b1100 : 4'b0011;
                wd_s = {2{wdata_r[15:0]}};
            end
            default: begin
                be_s = 4'b1111;
                wd_s = wdata_r;
            end
        endcase
    end

    // FSM state, latency counter, request capture and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            op_r       <= 6'd0;
            addr_r     <= {(AW+2){1'b0}};
            wdata_r    <= 32'd0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            rdata_r    <= 32'd0;
            ready_r    <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            ready_r    <= finish_s;
            addr_err_r <= finish_s && err_s;
            rdata_r    <= (finish_s && rd_r && !err_s) ? load_val_s : 32'd0;
            if (state_r == IDLE && req_s) begin
                cnt_r   <= CW'(LATENCY - 1);
                op_r    <= opcode;
                addr_r  <= addr[AW+1:0];
                wdata_r <= wdata;
                rd_r    <= mem_read;
                wr_r    <= mem_write;
            end else if (state_r == BUSY && cnt_r != {CW{1'b0}}) begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // RAM write port; contents survive reset, and reset forces IDLE so no commit occurs
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) mem_r[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [5:0]  opcode;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, stall, addr_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [5:0] LB = 6'd32, LH = 6'd33, LW = 6'd35, LBU = 6'd36, LHU = 6'd37;
    localparam logic [5:0] SB = 6'd40, SH = 6'd41, SW = 6'd43;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .opcode(opcode), .addr(addr), .wdata(wdata), .rdata(rdata),
        .ready(ready), .stall(stall), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Called at a negedge; holds the request until ready, returns at the next negedge.
    task automatic access(input logic rd, input logic wr, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdo, output logic erro,
                          output int lat, output int stalls, output logic ready_after);
        mem_read = rd; mem_write = wr; opcode = op; addr = a; wdata = wd;
        lat = -1; stalls = 0; rdo = 32'hX; erro = 1'bX;
        #1;
        if (stall) stalls++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (ready) begin
                lat = k; rdo = rdata; erro = addr_err;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        ready_after = ready;
    endtask

    logic [31:0] r;
    logic        e, ra;
    int          lat, st;

    task automatic test_reset();
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; opcode = 6'd0; addr = 32'd0; wdata = 32'd0;
        #1;
        total_cnt++; if ({rdata, ready, addr_err, stall} !== 35'd0) $display("FAIL reset_outputs: got rdata=%h ready=%b err=%b stall=%b required 0", rdata, ready, addr_err, stall); else pass_cnt++;
        mem_read = 1'b1; #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL reset_stall_eq: got %b required 1", stall); else pass_cnt++;
        mem_read = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        access(1'b0, 1'b1, SW, 32'h10, 32'hDEADBEEF, r, e, lat, st, ra);
        total_cnt++; if (lat !== 3) $display("FAIL sw_latency: got %0d required 3", lat); else pass_cnt++;
        total_cnt++; if (st !== 3) $display("FAIL sw_stall_cycles: got %0d required 3", st); else pass_cnt++;
        total_cnt++; if ({r, e} !== 33'd0) $display("FAIL sw_done: got rdata=%h err=%b required 0/0", r, e); else pass_cnt++;
        total_cnt++; if (ra !== 1'b0) $display("FAIL sw_ready_pulse: got %b required 0", ra); else pass_cnt++;
        access(1'b1, 1'b0, LW, 32'h10, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (lat !== 3) $display("FAIL lw_latency: got %0d required 3", lat); else pass_cnt++;
        total_cnt++; if (st !== 3) $display("FAIL lw_stall_cycles: got %0d required 3", st); else pass_cnt++;
        total_cnt++; if (r !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL lw_data: got %h err=%b required deadbeef/0", r, e); else pass_cnt++;
        total_cnt++; if (rdata !== 32'd0) $display("FAIL lw_rdata_cleared: got %h required 0", rdata); else pass_cnt++;
    endtask

    task automatic test_byte();
        access(1'b0, 1'b1, SW, 32'h20, 32'h11223344, r, e, lat, st, ra);
        access(1'b0, 1'b1, SB, 32'h21, 32'hFFFFFF80, r, e, lat, st, ra);
        total_cnt++; if (lat !== 3 || e !== 1'b0) $display("FAIL sb_done: got lat=%0d err=%b required 3/0", lat, e); else pass_cnt++;
        access(1'b1, 1'b0, LB, 32'h21, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'hFFFFFF80) $display("FAIL lb_sext: got %h required ffffff80", r); else pass_cnt++;
        access(1'b1, 1'b0, LBU, 32'h21, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'h00000080) $display("FAIL lbu_zext: got %h required 00000080", r); else pass_cnt++;
        access(1'b1, 1'b0, LW, 32'h20, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'h11228044) $display("FAIL sb_lane: got %h required 11228044", r); else pass_cnt++;
        access(1'b1, 1'b0, LBU, 32'h23, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'h00000011) $display("FAIL lbu_lane3: got %h required 00000011", r); else pass_cnt++;
    endtask

    task automatic test_half();
        access(1'b0, 1'b1, SW, 32'h30, 32'hCAFEF00D, r, e, lat, st, ra);
        access(1'b0, 1'b1, SH, 32'h32, 32'h55558001, r, e, lat, st, ra);
        access(1'b1, 1'b0, LH, 32'h32, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'hFFFF8001) $display("FAIL lh_sext: got %h required ffff8001", r); else pass_cnt++;
        access(1'b1, 1'b0, LHU, 32'h32, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'h00008001) $display("FAIL lhu_zext: got %h required 00008001", r); else pass_cnt++;
        access(1'b1, 1'b0, LW, 32'h30, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'h8001F00D) $display("FAIL sh_lanes: got %h required 8001f00d", r); else pass_cnt++;
    endtask

    task automatic test_errors();
        access(1'b1, 1'b0, LW, 32'h13, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (lat !== 3 || e !== 1'b1 || r !== 32'd0) $display("FAIL lw_misaligned: got lat=%0d err=%b rdata=%h required 3/1/0", lat, e, r); else pass_cnt++;
        total_cnt++; if (addr_err !== 1'b0) $display("FAIL err_pulse: got %b required 0", addr_err); else pass_cnt++;
        access(1'b0, 1'b1, SW, 32'h12, 32'h55555555, r, e, lat, st, ra);
        total_cnt++; if (e !== 1'b1 || r !== 32'd0) $display("FAIL sw_misaligned: got err=%b rdata=%h required 1/0", e, r); else pass_cnt++;
        access(1'b1, 1'b0, LW, 32'h10, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'hDEADBEEF) $display("FAIL sw_misaligned_nowrite: got %h required deadbeef", r); else pass_cnt++;
        access(1'b1, 1'b1, LW, 32'h10, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (e !== 1'b1 || r !== 32'd0) $display("FAIL rd_wr_both: got err=%b rdata=%h required 1/0", e, r); else pass_cnt++;
        access(1'b1, 1'b0, 6'd34, 32'h10, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (e !== 1'b1 || r !== 32'd0) $display("FAIL bad_opcode: got err=%b rdata=%h required 1/0", e, r); else pass_cnt++;
        access(1'b1, 1'b0, LHU, 32'h31, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (e !== 1'b1 || r !== 32'd0) $display("FAIL lhu_misaligned: got err=%b rdata=%h required 1/0", e, r); else pass_cnt++;
        access(1'b1, 1'b0, LB, 32'h13, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (e !== 1'b0) $display("FAIL lb_odd_ok: got err=%b required 0", e); else pass_cnt++;
    endtask

    task automatic test_wrap();
        access(1'b0, 1'b1, SW, 32'h404, 32'h12345678, r, e, lat, st, ra);
        access(1'b1, 1'b0, LW, 32'h4, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (r !== 32'h12345678) $display("FAIL wrap: got %h required 12345678", r); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int first, second, n;
        logic [31:0] d1, d2;
        first = -1; second = -1; d1 = 32'd0; d2 = 32'd0;
        mem_read = 1'b1; mem_write = 1'b0; opcode = LW; addr = 32'h10;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready && first < 0) begin first = n; d1 = rdata; end
            else if (ready) begin second = n; d2 = rdata; break; end
        end
        mem_read = 1'b0;
        @(negedge clk);
        total_cnt++; if (second - first !== 4) $display("FAIL b2b_gap: got %0d required 4", second - first); else pass_cnt++;
        total_cnt++; if (d1 !== 32'hDEADBEEF || d2 !== 32'hDEADBEEF) $display("FAIL b2b_data: got %h %h required deadbeef", d1, d2); else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        access(1'b0, 1'b1, SW, 32'h8, 32'h0BADF00D, r, e, lat, st, ra);
        mem_read = 1'b0; mem_write = 1'b1; opcode = SW; addr = 32'h8; wdata = 32'hAAAAAAAA;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt++; if ({rdata, ready, addr_err} !== 34'd0) $display("FAIL busy_reset_outputs: got rdata=%h ready=%b err=%b required 0", rdata, ready, addr_err); else pass_cnt++;
        @(negedge clk);
        mem_write = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        access(1'b1, 1'b0, LW, 32'h8, 32'h0, r, e, lat, st, ra);
        total_cnt++; if (lat !== 3) $display("FAIL busy_reset_idle: got lat=%0d required 3", lat); else pass_cnt++;
        total_cnt++; if (r !== 32'h0BADF00D) $display("FAIL busy_reset_nowrite: got %h required 0badf00d", r); else pass_cnt++;
        // Reset during DONE must drop the pulse and data immediately
        mem_read = 1'b1; opcode = LW; addr = 32'h8;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready) break;
        end
        total_cnt++; if (ready !== 1'b1 || rdata !== 32'h0BADF00D) $display("FAIL done_before_reset: got ready=%b rdata=%h required 1/0badf00d", ready, rdata); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if ({rdata, ready, addr_err} !== 34'd0) $display("FAIL done_reset_outputs: got rdata=%h ready=%b err=%b required 0", rdata, ready, addr_err); else pass_cnt++;
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_wrap();
        test_back_to_back();
        test_reset_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
